// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_state_t;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

endpackage

// File: rtl/demux1x2_stream_if.sv
// Bundle of the producer-side and both consumer-side handshakes of the demux.
interface demux1x2_stream_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    // The environment side: drives the producer stream and the consumer readys.
    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/stream_fifo2.sv
// Two-entry output buffer with valid/ready handshake and a wrapping transfer counter.
module stream_fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    output logic             valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    fifo_state_t      state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push_ok = push && (state_q != TWO);
        pop     = (state_q != EMPTY) && pop_ready;

        if (pop) begin
            count_d = count_q + CNT_W'(1);
        end

        // Push and pop together in ONE replaces the head in place.
        unique case (state_q)
            EMPTY: begin
                if (push_ok) begin
                    head_d  = push_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push_ok && pop) begin
                    head_d = push_data;
                end else if (push_ok) begin
                    tail_d  = push_data;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign ready = (state_q != TWO);
    assign valid = (state_q != EMPTY);
    assign data  = head_q;
    assign count = count_q;

endmodule

// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demultiplexer: steers each accepted word into the buffer chosen by in_sel.
module demux1x2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    demux1x2_stream_if.slave  bus
);

    logic a_space;
    logic b_space;
    logic in_ready;
    logic a_push;
    logic b_push;

    // in_ready only looks at in_sel and buffer state, never at in_valid.
    assign in_ready = rst_n && ((bus.in_sel == DEMUX_SEL_B) ? b_space : a_space);
    assign a_push   = bus.in_valid && in_ready && (bus.in_sel == DEMUX_SEL_A);
    assign b_push   = bus.in_valid && in_ready && (bus.in_sel == DEMUX_SEL_B);

    assign bus.in_ready = in_ready;

    stream_fifo2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (bus.in_data),
        .ready     (a_space),
        .valid     (bus.a_valid),
        .pop_ready (bus.a_ready),
        .data      (bus.a_data),
        .count     (bus.a_count)
    );

    stream_fifo2 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (bus.in_data),
        .ready     (b_space),
        .valid     (bus.b_valid),
        .pop_ready (bus.b_ready),
        .data      (bus.b_data),
        .count     (bus.b_count)
    );

endmodule

// File: tb/tb_demux1x2_stream.sv
// Directed and scoreboarded random checks for demux1x2_stream.
module tb_demux1x2_stream;
    import demux_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    demux1x2_stream_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checkCount = 0;
    int errorCount = 0;
    int acceptedWords = 0;
    int modelACount = 0;
    int modelBCount = 0;
    logic [31:0] queueA[$];
    logic [31:0] queueB[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive all inputs, then let combinational outputs settle before sampling.
    task automatic applyStimulus(input logic valid, input logic sel, input logic [31:0] data,
                                 input logic aReady, input logic bReady);
        bus.in_valid = valid;
        bus.in_sel   = sel;
        bus.in_data  = data;
        bus.a_ready  = aReady;
        bus.b_ready  = bReady;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One random cycle checked against a per-output queue model.
    task automatic randomStep(input logic valid, input logic sel, input logic [31:0] data,
                              input logic aReady, input logic bReady);
        logic expReady;
        logic aPop;
        logic bPop;
        logic inPush;
        applyStimulus(valid, sel, data, aReady, bReady);
        expReady = sel ? (queueB.size() < 2) : (queueA.size() < 2);
        checkOutput("rnd_in_ready", 32'(bus.in_ready), 32'(expReady));
        checkOutput("rnd_a_valid", 32'(bus.a_valid), 32'(queueA.size() != 0));
        checkOutput("rnd_b_valid", 32'(bus.b_valid), 32'(queueB.size() != 0));
        if (queueA.size() != 0) checkOutput("rnd_a_data", bus.a_data, queueA[0]);
        if (queueB.size() != 0) checkOutput("rnd_b_data", bus.b_data, queueB[0]);
        aPop   = (queueA.size() != 0) && aReady;
        bPop   = (queueB.size() != 0) && bReady;
        inPush = valid && expReady;
        tick();
        if (aPop) begin
            void'(queueA.pop_front());
            modelACount++;
        end
        if (bPop) begin
            void'(queueB.pop_front());
            modelBCount++;
        end
        if (inPush) begin
            acceptedWords++;
            if (sel) queueB.push_back(data);
            else     queueA.push_back(data);
        end
    endtask

    initial begin
        int cycles;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        #2 rst_n = 1'b0;

        $display("[TB] power-on reset");
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, DEMUX_SEL_A, 32'h1, 1'b1, 1'b1);
        checkOutput("por_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("por_a_valid", 32'(bus.a_valid), 32'h0);
        checkOutput("por_b_valid", 32'(bus.b_valid), 32'h0);
        checkOutput("por_a_count", 32'(bus.a_count), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b1);
        checkOutput("por_release_in_ready", 32'(bus.in_ready), 32'h1);
        tick();

        $display("[TB] alternating select");
        applyStimulus(1'b1, DEMUX_SEL_A, 32'h11111111, 1'b1, 1'b1);
        checkOutput("alt_in_ready0", 32'(bus.in_ready), 32'h1);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_B, 32'h22222222, 1'b1, 1'b1);
        checkOutput("alt_a_valid0", 32'(bus.a_valid), 32'h1);
        checkOutput("alt_a_data0", bus.a_data, 32'h11111111);
        checkOutput("alt_in_ready1", 32'(bus.in_ready), 32'h1);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'h33333333, 1'b1, 1'b1);
        checkOutput("alt_b_valid", 32'(bus.b_valid), 32'h1);
        checkOutput("alt_b_data", bus.b_data, 32'h22222222);
        checkOutput("alt_a_idle", 32'(bus.a_valid), 32'h0);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b1);
        checkOutput("alt_a_data1", bus.a_data, 32'h33333333);
        checkOutput("alt_b_idle", 32'(bus.b_valid), 32'h0);
        tick();
        checkOutput("alt_a_count", 32'(bus.a_count), 32'd2);
        checkOutput("alt_b_count", 32'(bus.b_count), 32'd1);

        $display("[TB] backpressure and isolation");
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hA0, 1'b0, 1'b1);
        checkOutput("bp_in_ready_a0", 32'(bus.in_ready), 32'h1);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hA1, 1'b0, 1'b1);
        checkOutput("bp_in_ready_a1", 32'(bus.in_ready), 32'h1);
        checkOutput("bp_a_data_a0", bus.a_data, 32'hA0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hA2, 1'b0, 1'b1);
        checkOutput("bp_in_ready_a2", 32'(bus.in_ready), 32'h0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_B, 32'hB5, 1'b0, 1'b1);
        checkOutput("iso_in_ready_b", 32'(bus.in_ready), 32'h1);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b0, 1'b0);
        checkOutput("iso_b_valid", 32'(bus.b_valid), 32'h1);
        checkOutput("iso_b_data", bus.b_data, 32'hB5);
        checkOutput("iso_a_data", bus.a_data, 32'hA0);
        checkOutput("iso_a_full", 32'(bus.in_ready), 32'h0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hA2, 1'b1, 1'b1);
        checkOutput("bp_still_full", 32'(bus.in_ready), 32'h0);
        checkOutput("bp_out_a0", bus.a_data, 32'hA0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hA2, 1'b1, 1'b0);
        checkOutput("bp_ready_rise", 32'(bus.in_ready), 32'h1);
        checkOutput("bp_out_a1", bus.a_data, 32'hA1);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_out_a2", bus.a_data, 32'hA2);
        checkOutput("bp_out_a2_valid", 32'(bus.a_valid), 32'h1);
        tick();
        checkOutput("bp_a_drained", 32'(bus.a_valid), 32'h0);
        checkOutput("bp_a_count", 32'(bus.a_count), 32'd5);
        checkOutput("bp_b_count", 32'(bus.b_count), 32'd2);

        $display("[TB] push and pop in ONE");
        applyStimulus(1'b1, DEMUX_SEL_A, 32'h5, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'h6, 1'b1, 1'b0);
        checkOutput("pp_a_data_5", bus.a_data, 32'h5);
        checkOutput("pp_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b0, 1'b0);
        checkOutput("pp_a_data_6", bus.a_data, 32'h6);
        checkOutput("pp_still_one", 32'(bus.in_ready), 32'h1);
        checkOutput("pp_a_count", 32'(bus.a_count), 32'd6);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pp_a_count_drain", 32'(bus.a_count), 32'd7);

        $display("[TB] reset with both buffers full");
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hC0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hC1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_B, 32'hD0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_B, 32'hD1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, DEMUX_SEL_A, 32'hC2, 1'b0, 1'b0);
        checkOutput("rst_pre_a_full", 32'(bus.in_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("rst_a_valid", 32'(bus.a_valid), 32'h0);
        checkOutput("rst_b_valid", 32'(bus.b_valid), 32'h0);
        checkOutput("rst_a_data", bus.a_data, 32'h0);
        checkOutput("rst_b_data", bus.b_data, 32'h0);
        checkOutput("rst_a_count", 32'(bus.a_count), 32'h0);
        checkOutput("rst_b_count", 32'(bus.b_count), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("rst_release_a", 32'(bus.in_ready), 32'h1);
        applyStimulus(1'b1, DEMUX_SEL_B, 32'hD2, 1'b0, 1'b0);
        checkOutput("rst_release_b", 32'(bus.in_ready), 32'h1);
        applyStimulus(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b1);
        tick();

        $display("[TB] counter wrap on B");
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(1'b1, DEMUX_SEL_B, 32'(i), 1'b1, 1'b1);
            tick();
        end
        applyStimulus(1'b0, DEMUX_SEL_B, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("wrap_b_count_max", 32'(bus.b_count), 32'h0000FFFF);
        checkOutput("wrap_a_untouched", 32'(bus.a_count), 32'h0);
        applyStimulus(1'b1, DEMUX_SEL_B, 32'hF00D, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, DEMUX_SEL_B, 32'h0, 1'b1, 1'b1);
        tick();
        checkOutput("wrap_b_count_zero", 32'(bus.b_count), 32'h0);

        $display("[TB] random traffic");
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        cycles = 0;
        while (acceptedWords < 1000 && cycles < 20000) begin
            randomStep(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            cycles++;
        end
        checkOutput("rnd_budget", 32'(acceptedWords >= 1000), 32'h1);
        repeat (4) randomStep(1'b0, DEMUX_SEL_A, 32'h0, 1'b1, 1'b1);
        checkOutput("rnd_queue_a_empty", 32'(queueA.size()), 32'h0);
        checkOutput("rnd_queue_b_empty", 32'(queueB.size()), 32'h0);
        checkOutput("rnd_a_count", 32'(bus.a_count), 32'(modelACount % 65536));
        checkOutput("rnd_b_count", 32'(bus.b_count), 32'(modelBCount % 65536));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/demux1x2_stream.md
# demux1x2_stream

Pipelined 1-to-2 stream demultiplexer with valid/ready handshakes on every port. It is the distribution-side counterpart of the 2:1 datapath mux: one 32-bit producer stream is routed word-by-word to output A or B, selected by a per-word select bit. Each output has a 2-entry buffer, so the block sustains full throughput and keeps each output's word order. It sits between a single producer (e.g. writeback/result bus) and two independent consumers.

## Interface
- `WIDTH`, default 32: data width of all streams.
- `CNT_W`, default 16: width of the per-output transfer counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input WIDTH: input word.
- `in_sel` input 1: destination. 0 routes to A, 1 routes to B. Qualified by `in_valid`.
- `in_valid` input 1: input word and select are valid.
- `in_ready` output 1: block accepts the word this cycle.
- `a_data` output WIDTH: output A word.
- `a_valid` output 1: output A word is valid.
- `a_ready` input 1: consumer A accepts.
- `b_data`, `b_valid`, `b_ready`: as for A, for output B.
- `a_count` output CNT_W: words delivered on A since reset.
- `b_count` output CNT_W: words delivered on B since reset.

## Operation
- Input transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_ready` = `in_sel ? !b_full : !a_full`, and is forced 0 while `rst_n` is low.
  - The only combinational path is `in_sel` to `in_ready`. Data paths are registered.
- Output transfer occurs when `x_valid && x_ready` at a rising edge.
- Per-output buffer is a 2-entry FIFO with states EMPTY, ONE, TWO.
  - EMPTY to ONE on push.
  - ONE to TWO on push without pop.
  - ONE to EMPTY on pop without push.
  - ONE to ONE on simultaneous push and pop: the head is replaced by the new word.
  - TWO to ONE on pop. Push in TWO is impossible because ready is low.
  - `x_valid` = state != EMPTY. `x_full` = state == TWO.
  - `x_data` = head entry.
- Words accepted for the same output leave in acceptance order. There is no ordering guarantee between A and B.
- The unselected output is never written. Its state is unaffected by input traffic.
- `in_data` and `in_sel` while `in_valid` is low are ignored. They may be X.
- Counters increment by 1 on each output transfer. They wrap modulo 2^CNT_W: 0xFFFF + 1 gives 0x0000.
- Reset, asserted at any time including mid-transfer:
  - Both buffers go to EMPTY.
  - All `x_valid` = 0, all `x_data` = 0, counts = 0, `in_ready` = 0.
  - Buffered words are discarded.
  - After deassertion, `in_ready` reflects the empty buffers (1) from the first cycle.

## Timing
- Latency: a word accepted at edge N is presented on `x_data`/`x_valid` in the cycle after edge N. The output is registered.
- Throughput: 1 word/cycle per output when the consumer holds ready high. Total throughput is 1 word/cycle.
- `x_ready` low for k cycles:
  - At most 2 words are held.
  - `in_ready` for that destination drops after the second word is accepted.
  - `in_ready` rises in the cycle after the first pop.
- Once `x_valid` is asserted, `x_valid` and `x_data` stay stable until popped.
- `in_ready` must not depend on `in_valid`.

## Structure
- Shared package `demux_pkg`:
  - `typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_state_t`
  - `DEMUX_SEL_A = 1'b0`, `DEMUX_SEL_B = 1'b1`
- One sub-module, `stream_fifo2`, instantiated twice. It contains:
  - the 2-entry buffer and its state machine
  - `push`/`full`/`valid`/`ready` logic
  - the transfer counter
- The top level contains only steering (push enables, `in_ready` mux).

## Test plan
- Reset: drive `rst_n`=0 mid-stream with both buffers TWO. Required: `a_valid`=`b_valid`=0, data=0, counts=0, `in_ready`=0 immediately. After release, `in_ready`=1.
- Alternating sel: send 0x11111111 (sel 0), 0x22222222 (sel 1), 0x33333333 (sel 0) back-to-back, both readys high. Required:
  - A emits 0x11111111 then 0x33333333; B emits 0x22222222.
  - Each word appears 1 cycle after acceptance.
  - `a_count`=2, `b_count`=1.
- Backpressure: `a_ready`=0, send 0xA0, 0xA1, 0xA2 to A. Required:
  - 0xA0 and 0xA1 accepted; `in_ready`=0 on 0xA2.
  - Raise `a_ready`: 0xA0, 0xA1, 0xA2 emerge in order.
- Isolation: A full (`a_ready`=0), send 0xB5 with sel 1. Required: accepted the same cycle, `b_data`=0xB5 next cycle, A contents unchanged.
- Simultaneous push/pop in ONE: A holds 0x5, `a_ready`=1, push 0x6. Required: state stays ONE, `a_data`=0x6 next cycle, `a_count` increments.
- Counter wrap: force 0xFFFF transfers on B, then one more. Required: `b_count`=0x0000.
- Random: 1000 random words/sel/readys checked against a scoreboard with one queue per output.
